// File: rtl/div_unit.sv
// div_unit: 32-bit iterative integer divider (DIV, DIVU, REM, REMU).
//
// A restoring radix-2 divider produces one quotient bit per cycle over
// 32 cycles. Signed operations divide magnitudes, and the SIGN state
// fixes up the sign of the result. Division by zero and signed overflow
// skip the iteration and complete on the cycle after acceptance.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Start      request pulse; operands and op are sampled on the accepting edge
//   Src1       dividend
//   Src2       divisor
//   Div_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Flush      synchronous abort of any in-flight operation
//   Busy       high while Start cannot be accepted (CALC, SIGN)
//   Done       one-cycle completion pulse
//   Div_Result quotient or remainder; holds until the next completion
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic [1:0]  Div_op,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Div_Result
);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;       // partial remainder
  logic [31:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
  logic [31:0] dvs_q, dvs_d;       // divisor magnitude
  logic        rem_op_q, rem_op_d; // 1: return the remainder
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  logic        is_signed;
  logic [31:0] abs1, abs2;
  logic [32:0] shifted, diff;

  always_comb begin
    is_signed = ~Div_op[0];
    abs1      = (is_signed && Src1[31]) ? -Src1 : Src1;
    abs2      = (is_signed && Src2[31]) ? -Src2 : Src2;
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (Flush) begin
      // Abort wins over everything, including a same-cycle Start.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (Start) begin
            rem_op_d  = Div_op[1];
            neg_quo_d = is_signed & (Src1[31] ^ Src2[31]);
            neg_rem_d = is_signed & Src1[31];
            quo_d     = abs1;
            dvs_d     = abs2;
            rem_d     = '0;
            cnt_d     = '0;
            if (Src2 == 32'd0) begin
              result_d = Div_op[1] ? Src1 : 32'hFFFF_FFFF;
              state_d  = StDone;
            end else if (is_signed && Src1 == 32'h8000_0000 && Src2 == 32'hFFFF_FFFF) begin
              result_d = Div_op[1] ? 32'd0 : 32'h8000_0000;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          // Restore (keep shifted value) when the trial subtract borrows.
          rem_d = diff[32] ? shifted[31:0] : diff[31:0];
          quo_d = {quo_q[30:0], ~diff[32]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StSign;
        end
        StSign: begin
          if (rem_op_q) result_d = neg_rem_q ? -rem_q : rem_q;
          else          result_d = neg_quo_q ? -quo_q : quo_q;
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign Busy       = (state_q == StCalc) || (state_q == StSign);
  assign Done       = (state_q == StDone);
  assign Div_Result = result_q;

endmodule
